// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter sharing one slave-side bus between a register slave and a memory slave.
// Adds round-robin tie-breaking, address decode, unmapped-address errors and a wait-cycle timeout.
module wb_bus_arbiter #(
  parameter int unsigned  TIMEOUT  = 255,
  parameter logic [22:0]  REG_BASE = 23'h400000,
  parameter logic [22:0]  REG_MASK = 23'h7FFFF0,
  parameter logic [22:0]  MEM_MASK = 23'h400000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [22:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [22:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [22:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        reg_stb_o,
  output logic        mem_stb_o,
  input  logic        reg_ack_i,
  input  logic        mem_ack_i,
  input  logic [31:0] reg_dat_i,
  input  logic [31:0] mem_dat_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state;
  state_e      state_nxt;
  logic        last_owner;
  logic [7:0]  wait_cnt;
  logic        unmapped_q;
  logic        reg_hit;
  logic        mem_hit;
  logic        slv_ack;
  logic [31:0] slv_dat;
  logic        bus_err;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == GNT0 && !m0_cyc_i) last_owner <= 1'b0;
      if (state == GNT1 && !m1_cyc_i) last_owner <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_owner ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0:    if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_o = {state == GNT1, state == GNT0};

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Register window takes precedence over the memory window when both match.
  assign reg_hit   = s_stb_o && ((s_adr_o & REG_MASK) == REG_BASE);
  assign mem_hit   = s_stb_o && !reg_hit && ((s_adr_o & MEM_MASK) == '0);
  assign reg_stb_o = reg_hit;
  assign mem_stb_o = mem_hit;

  assign slv_ack = (reg_hit && reg_ack_i) || (mem_hit && mem_ack_i);
  assign slv_dat = reg_hit ? reg_dat_i : (mem_hit ? mem_dat_i : '0);
  // A late ack in the timeout cycle wins over the error.
  assign bus_err = !slv_ack && (unmapped_q || (s_stb_o && wait_cnt == TIMEOUT_CNT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt   <= '0;
      unmapped_q <= 1'b0;
    end else begin
      if (s_cyc_o && s_stb_o && !slv_ack && !bus_err) wait_cnt <= wait_cnt + 8'd1;
      else                                             wait_cnt <= '0;
      // Only flagged while the owner keeps cyc, so the error reaches the same master.
      unmapped_q <= s_cyc_o && s_stb_o && !reg_hit && !mem_hit && !unmapped_q;
    end
  end

  assign m0_ack_o = (state == GNT0) && slv_ack;
  assign m0_err_o = (state == GNT0) && bus_err;
  assign m0_dat_o = (state == GNT0) ? slv_dat : '0;
  assign m1_ack_o = (state == GNT1) && slv_ack;
  assign m1_err_o = (state == GNT1) && bus_err;
  assign m1_dat_o = (state == GNT1) ? slv_dat : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: constant vector table, directed corner sequences,
// and randomized traffic compared every cycle against an owner/queue-style reference model.
module tb_wb_bus_arbiter;

  localparam int          TIMEOUT  = 255;
  localparam logic [22:0] REG_BASE = 23'h400000;
  localparam logic [22:0] REG_MASK = 23'h7FFFF0;
  localparam logic [22:0] MEM_MASK = 23'h400000;
  localparam logic [22:0] A_MEM    = 23'h008000;
  localparam logic [22:0] A_REG    = 23'h400008;
  localparam logic [22:0] A_UNMAP  = 23'h400040;

  logic        clk;
  logic        rst_n;
  logic        mc [2];
  logic        ms [2];
  logic        mw [2];
  logic [3:0]  msel [2];
  logic [22:0] madr [2];
  logic [31:0] mdat [2];
  logic        reg_ack, mem_ack;
  logic [31:0] reg_dat, mem_dat;

  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o, reg_stb_o, mem_stb_o;
  logic [3:0]  s_sel_o;
  logic [22:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [1:0]  gnt_o;

  int errors = 0;
  int checks = 0;

  wb_bus_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .reg_stb_o(reg_stb_o), .mem_stb_o(mem_stb_o),
    .reg_ack_i(reg_ack), .mem_ack_i(mem_ack), .reg_dat_i(reg_dat), .mem_dat_i(mem_dat),
    .gnt_o(gnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference model: owner index (-1 = nobody), last owner, cycles the current strobe has waited,
  // and a pending one-shot unmapped error.
  int          own, last_own, waited;
  bit          unm;
  int          n_own, n_last, n_wait;
  bit          n_unm;
  logic [1:0]  exp_gnt;
  logic [63:0] exp_slv;
  logic [33:0] exp_m [2];

  always_comb begin
    bit          hit_reg, hit_mem, ack, err;
    logic [31:0] rdat;
    exp_gnt  = '0;
    exp_slv  = '0;
    exp_m[0] = '0;
    exp_m[1] = '0;
    n_own    = own;
    n_last   = last_own;
    n_wait   = 0;
    n_unm    = 1'b0;
    hit_reg  = 1'b0;
    hit_mem  = 1'b0;
    ack      = 1'b0;
    err      = 1'b0;
    rdat     = '0;
    if (own >= 0) begin
      exp_gnt = 2'(1 << own);
      if (ms[own]) begin
        hit_reg = (madr[own] & REG_MASK) == REG_BASE;
        hit_mem = !hit_reg && ((madr[own] & MEM_MASK) == 23'd0);
      end
      if (hit_reg)      begin ack = reg_ack; rdat = reg_dat; end
      else if (hit_mem) begin ack = mem_ack; rdat = mem_dat; end
      err = !ack && (unm || (ms[own] && waited == TIMEOUT));
      exp_slv = {mc[own], ms[own], mw[own], msel[own], madr[own], mdat[own], hit_reg, hit_mem};
      exp_m[own] = {ack, err, rdat};
      if (mc[own]) begin
        n_wait = (ms[own] && !ack && !err) ? waited + 1 : 0;
        n_unm  = ms[own] && !hit_reg && !hit_mem && !unm;
      end else begin
        n_last = own;
        n_own  = mc[1 - own] ? 1 - own : -1;
      end
    end else if (mc[0] && mc[1]) begin
      n_own = 1 - last_own;
    end else if (mc[0]) begin
      n_own = 0;
    end else if (mc[1]) begin
      n_own = 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own      <= -1;
      last_own <= 0;
      waited   <= 0;
      unm      <= 1'b0;
    end else begin
      own      <= n_own;
      last_own <= n_last;
      waited   <= n_wait;
      unm      <= n_unm;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    check("gnt", 64'(gnt_o), 64'(exp_gnt));
    check("slave_bus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, reg_stb_o, mem_stb_o},
          exp_slv);
    check("m0_resp", 64'({m0_ack_o, m0_err_o, m0_dat_o}), 64'(exp_m[0]));
    check("m1_resp", 64'({m1_ack_o, m1_err_o, m1_dat_o}), 64'(exp_m[1]));
  endtask

  task automatic at_sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        c0, s0, c1, s1, w1;
    logic [22:0] a0, a1;
    logic [31:0] d1;
    logic        mack, rack;
    logic [1:0]  gnt;
    logic [5:0]  outs;  // {m0_ack, m0_err, m1_ack, m1_err, reg_stb, mem_stb}
  } vec_t;

  vec_t tbl [11];

  initial begin
    int nerr, err_at;

    tbl[0]  = '{1, 1, 0, 0, 0, A_MEM, 0,     0,            0, 0, 2'b00, 6'b000000};
    tbl[1]  = '{1, 1, 0, 0, 0, A_MEM, 0,     0,            1, 0, 2'b01, 6'b100001};
    tbl[2]  = '{0, 0, 0, 0, 0, A_MEM, 0,     0,            0, 0, 2'b01, 6'b000000};
    tbl[3]  = '{1, 0, 1, 0, 0, 0,     0,     0,            0, 0, 2'b00, 6'b000000};
    tbl[4]  = '{1, 0, 0, 0, 0, 0,     0,     0,            0, 0, 2'b10, 6'b000000};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,     0,     0,            0, 0, 2'b01, 6'b000000};
    tbl[6]  = '{1, 0, 1, 0, 0, 0,     0,     0,            0, 0, 2'b00, 6'b000000};
    tbl[7]  = '{0, 0, 1, 1, 1, 0,     A_REG, 32'h00008000, 0, 0, 2'b10, 6'b000010};
    tbl[8]  = '{0, 0, 1, 1, 1, 0,     A_REG, 32'h00008000, 1, 1, 2'b10, 6'b001010};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,     0,     0,            0, 0, 2'b10, 6'b000000};
    tbl[10] = '{0, 0, 0, 0, 0, 0,     0,     0,            0, 0, 2'b00, 6'b000000};

    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0;
      msel[m] = 4'hF; madr[m] = '0; mdat[m] = 32'hC0DE_0000 + 32'(m);
    end
    mem_dat = 32'hA5A5_0001;
    reg_dat = 32'h5A5A_0002;
    reg_ack = 1'b0;

    // Requests and slave acks held during reset must produce nothing.
    mc[0] = 1'b1; ms[0] = 1'b1; madr[0] = A_MEM; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_bus", 64'({s_cyc_o, s_stb_o, reg_stb_o, mem_stb_o}), 64'd0);
    check("rst_m0", 64'({m0_ack_o, m0_err_o, m0_dat_o}), 64'd0);
    check("rst_m1", 64'({m1_ack_o, m1_err_o, m1_dat_o}), 64'd0);
    mc[0] = 1'b0; ms[0] = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    to_next();

    for (int i = 0; i < 11; i++) begin
      mc[0] = tbl[i].c0; ms[0] = tbl[i].s0; madr[0] = tbl[i].a0;
      mc[1] = tbl[i].c1; ms[1] = tbl[i].s1; mw[1] = tbl[i].w1;
      madr[1] = tbl[i].a1; mdat[1] = tbl[i].d1;
      mem_ack = tbl[i].mack; reg_ack = tbl[i].rack;
      @(negedge clk);
      check($sformatf("row%0d", i),
            64'({gnt_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, reg_stb_o, mem_stb_o}),
            64'({tbl[i].gnt, tbl[i].outs}));
      model_check();
      to_next();
    end

    // m0 keeps cyc over 100 acked strobes while m1 waits.
    mw[1] = 1'b0; mem_ack = 1'b0; reg_ack = 1'b0;
    mc[0] = 1'b1; mc[1] = 1'b1; madr[0] = A_MEM; madr[1] = A_MEM;
    at_sample();
    to_next();
    for (int n = 0; n < 100; n++) begin
      ms[0] = 1'b1;
      at_sample();
      check("hold_gnt", 64'(gnt_o), 64'b01);
      to_next();
      mem_ack = 1'b1;
      at_sample();
      to_next();
      ms[0] = 1'b0; mem_ack = 1'b0;
      at_sample();
      to_next();
    end
    mc[0] = 1'b0;
    at_sample();
    check("drop_gnt_same", 64'(gnt_o), 64'b01);
    to_next();
    at_sample();
    check("handoff_gnt", 64'(gnt_o), 64'b10);
    to_next();

    // Timeout with mem_ack held low; stb stays up afterwards.
    ms[1] = 1'b1; madr[1] = A_MEM;
    nerr = 0; err_at = 0;
    for (int k = 1; k <= 300; k++) begin
      at_sample();
      if (m1_err_o) begin nerr++; err_at = k; end
      if (k == 257) check("stb_after_timeout", 64'(mem_stb_o), 64'd1);
      to_next();
    end
    check("timeout_count", 64'(nerr), 64'd1);
    check("timeout_cycle", 64'(err_at), 64'd256);
    ms[1] = 1'b0;
    at_sample();
    to_next();

    // Ack landing in the timeout cycle suppresses err.
    ms[1] = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      mem_ack = (k == 256);
      at_sample();
      if (k == 256) check("ack_beats_timeout", 64'({m1_ack_o, m1_err_o}), 64'b10);
      to_next();
    end
    ms[1] = 1'b0; mem_ack = 1'b0;
    at_sample();
    to_next();

    // Owner drops cyc mid-wait: no err now or on the next long wait.
    ms[1] = 1'b1;
    repeat (100) begin at_sample(); to_next(); end
    mc[1] = 1'b0;
    at_sample();
    to_next();
    ms[1] = 1'b0; mc[1] = 1'b1;
    at_sample();
    to_next();
    ms[1] = 1'b1;
    nerr = 0;
    for (int k = 1; k <= 200; k++) begin
      at_sample();
      if (m1_err_o) nerr++;
      to_next();
    end
    check("no_err_after_drop", 64'(nerr), 64'd0);
    ms[1] = 1'b0;
    at_sample();
    to_next();

    // Unmapped address: err exactly on the following cycle.
    ms[1] = 1'b1; madr[1] = A_UNMAP;
    at_sample();
    check("unmap_same_cycle", 64'({m1_ack_o, m1_err_o}), 64'b00);
    to_next();
    ms[1] = 1'b0;
    at_sample();
    check("unmap_err", 64'({m1_ack_o, m1_err_o}), 64'b01);
    to_next();
    at_sample();
    check("unmap_err_gone", 64'(m1_err_o), 64'd0);
    to_next();

    // Reset in the middle of an acked transfer, then first tie after release goes to m1.
    ms[1] = 1'b1; madr[1] = A_MEM; mem_ack = 1'b1;
    at_sample();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_gnt", 64'(gnt_o), 64'd0);
    check("midrst_m1", 64'({m1_ack_o, m1_err_o, s_stb_o, mem_stb_o}), 64'd0);
    mc[0] = 1'b1; mc[1] = 1'b1; ms[0] = 1'b0; ms[1] = 1'b0; mem_ack = 1'b0;
    to_next();
    @(negedge clk);
    rst_n = 1'b1;
    to_next();
    at_sample();
    check("first_tie_after_rst", 64'(gnt_o), 64'b10);
    to_next();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(7) == 0) mc[m] = ~mc[m];
        ms[m]   = mc[m] & 1'($urandom_range(1));
        mw[m]   = 1'($urandom_range(1));
        msel[m] = 4'($urandom);
        mdat[m] = $urandom;
        case ($urandom_range(3))
          0:       madr[m] = {1'b0, 22'($urandom)};
          1:       madr[m] = REG_BASE | 23'($urandom_range(15));
          2:       madr[m] = A_UNMAP + 23'($urandom_range(255));
          default: madr[m] = 23'($urandom);
        endcase
      end
      mem_ack = ($urandom_range(2) == 0);
      reg_ack = ($urandom_range(2) == 0);
      mem_dat = $urandom;
      reg_dat = $urandom;
      at_sample();
      to_next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
